// File: rtl/alu_exec_stage_if.sv
// Operand/result bundle of the execute stage. The `overflow` signal exists
// only when ALU_OVERFLOW_EN is defined.
interface alu_exec_stage_if #(
  parameter int WIDTH = 32
);
  logic             ALUSrcA;
  logic             ALUSrcB;
  logic [2:0]       ALUOp;
  logic [WIDTH-1:0] ReadData1;
  logic [WIDTH-1:0] ReadData2;
  logic [4:0]       sa;
  logic [WIDTH-1:0] ExtendOut;
  logic             ALUOutWre;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] ALUResult;
  logic             zero;
  logic [WIDTH-1:0] ALUOutReg;
`ifdef ALU_OVERFLOW_EN
  logic             overflow;

  modport master (
    output ALUSrcA, ALUSrcB, ALUOp, ReadData1, ReadData2, sa, ExtendOut, ALUOutWre,
    input  A, B, ALUResult, zero, ALUOutReg, overflow
  );

  modport slave (
    input  ALUSrcA, ALUSrcB, ALUOp, ReadData1, ReadData2, sa, ExtendOut, ALUOutWre,
    output A, B, ALUResult, zero, ALUOutReg, overflow
  );
`else
  modport master (
    output ALUSrcA, ALUSrcB, ALUOp, ReadData1, ReadData2, sa, ExtendOut, ALUOutWre,
    input  A, B, ALUResult, zero, ALUOutReg
  );

  modport slave (
    input  ALUSrcA, ALUSrcB, ALUOp, ReadData1, ReadData2, sa, ExtendOut, ALUOutWre,
    output A, B, ALUResult, zero, ALUOutReg
  );
`endif
endinterface

// File: rtl/alu_exec_stage.sv
// Execute stage of the multicycle MIPS-subset CPU: operand select, ALU, zero flag, result register.
// Optional feature macro: ALU_OVERFLOW_EN adds a combinational signed-overflow flag for add/sub.
module alu_exec_stage #(
  parameter int WIDTH = 32
) (
  input logic              CLK,
  input logic              RST,
  alu_exec_stage_if.slave  bus
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_SLL  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_SLTU = 3'b101;
  localparam logic [2:0] OP_SLT  = 3'b110;
  localparam logic [2:0] OP_XOR  = 3'b111;

  // Compare ops produce a single bit that is zero-extended to the datapath.
  function automatic logic [WIDTH-1:0] alu_compute(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH-1:0] r;
    r = {WIDTH{1'b0}};
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_SLL:  r = b << a[4:0];
      OP_OR:   r = a | b;
      OP_AND:  r = a & b;
      OP_SLTU: r = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLT:  r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_XOR:  r = a ^ b;
      default: r = {WIDTH{1'b0}};
    endcase
    return r;
  endfunction

`ifdef ALU_OVERFLOW_EN
  // Two's-complement overflow: add overflows when like-signed operands give an
  // opposite-signed sum; sub overflows when unlike-signed operands do the same.
  function automatic logic alu_overflow(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [WIDTH-1:0] r
  );
    logic ov;
    ov = 1'b0;
    case (op)
      OP_ADD:  ov = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      OP_SUB:  ov = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      default: ov = 1'b0;
    endcase
    return ov;
  endfunction
`endif

  logic [WIDTH-1:0] a_s;
  logic [WIDTH-1:0] b_s;
  logic [WIDTH-1:0] result_s;
  logic             zero_s;
  logic [WIDTH-1:0] alu_out_d;
  logic [WIDTH-1:0] alu_out_q;

  // Operand selection
  always_comb begin
    a_s = {WIDTH{1'b0}};
    b_s = {WIDTH{1'b0}};
    if (bus.ALUSrcA) begin
      a_s = {{(WIDTH-5){1'b0}}, bus.sa};
    end else begin
      a_s = bus.ReadData1;
    end
    if (bus.ALUSrcB) begin
      b_s = bus.ExtendOut;
    end else begin
      b_s = bus.ReadData2;
    end
  end

  // Function unit and zero flag
  always_comb begin
    result_s = alu_compute(bus.ALUOp, a_s, b_s);
    zero_s   = (result_s == {WIDTH{1'b0}});
  end

  // Result register next-state
  always_comb begin
    alu_out_d = alu_out_q;
    if (bus.ALUOutWre) begin
      alu_out_d = result_s;
    end else begin
      alu_out_d = alu_out_q;
    end
  end

  // Result register; reset clears it regardless of the load enable
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      alu_out_q <= {WIDTH{1'b0}};
    end else begin
      alu_out_q <= alu_out_d;
    end
  end

  assign bus.A         = a_s;
  assign bus.B         = b_s;
  assign bus.ALUResult = result_s;
  assign bus.zero      = zero_s;
  assign bus.ALUOutReg = alu_out_q;
`ifdef ALU_OVERFLOW_EN
  assign bus.overflow  = alu_overflow(bus.ALUOp, a_s, b_s, result_s);
`endif

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: combinational checks inline, registered
// result checked through a scoreboard queue filled at stimulus time.
module tb_alu_exec_stage;
  localparam int W = 32;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  alu_exec_stage_if #(.WIDTH(W)) bus();
  alu_exec_stage #(.WIDTH(W)) u_dut (.CLK(CLK), .RST(RST), .bus(bus));

  int n_pass  = 0;
  int n_total = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] model_reg = 32'h0;
  logic [W-1:0] got;
  logic [W-1:0] want;

  function automatic logic [W-1:0] ref_alu(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic signed [W-1:0] sa_v;
    logic signed [W-1:0] sb_v;
    sa_v = a;
    sb_v = b;
    case (op)
      3'd0:    return a + b;
      3'd1:    return a + (~b) + 32'd1;
      3'd2:    return b << a[4:0];
      3'd3:    return a | b;
      3'd4:    return a & b;
      3'd5:    return (a < b) ? 32'd1 : 32'd0;
      3'd6:    return (sa_v < sb_v) ? 32'd1 : 32'd0;
      default: return a ^ b;
    endcase
  endfunction

  task automatic drive(input logic srca, input logic srcb, input logic [2:0] op,
                       input logic [W-1:0] rd1, input logic [W-1:0] rd2,
                       input logic [4:0] sav, input logic [W-1:0] ext, input logic wre);
    @(negedge CLK);
    bus.ALUSrcA   = srca;
    bus.ALUSrcB   = srcb;
    bus.ALUOp     = op;
    bus.ReadData1 = rd1;
    bus.ReadData2 = rd2;
    bus.sa        = sav;
    bus.ExtendOut = ext;
    bus.ALUOutWre = wre;
  endtask

  // Pops one scoreboard entry after the clock edge and compares the register.
  task automatic edge_and_check(input string name);
    @(posedge CLK);
    #1;
    n_total++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s: scoreboard empty, ALUOutReg=%h", name, bus.ALUOutReg);
    end else begin
      want = exp_q.pop_front();
      if (bus.ALUOutReg !== want)
        $display("FAIL %s: ALUOutReg got %h expected %h", name, bus.ALUOutReg, want);
      else
        n_pass++;
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    drive(1'b0, 1'b0, 3'b000, 32'd5, 32'd7, 5'd0, 32'd0, 1'b1);
    repeat (2) @(posedge CLK);
    #1;
    n_total++;
    if (bus.ALUOutReg !== 32'd0) $display("FAIL reset_clear: got %h expected 0", bus.ALUOutReg);
    else n_pass++;
    n_total++;
    if (bus.ALUResult !== 32'd12) $display("FAIL reset_comb: got %h expected 12", bus.ALUResult);
    else n_pass++;
    @(negedge CLK);
    RST = 1'b1;
    model_reg = ref_alu(3'b000, 32'd5, 32'd7);
    exp_q.push_back(model_reg);
    edge_and_check("reset_first_load");
  endtask

  task automatic test_shift();
    drive(1'b1, 1'b0, 3'b010, 32'hDEAD_0000, 32'h1, 5'd2, 32'h0, 1'b1);
    #1;
    n_total++;
    if (bus.A !== 32'd2) $display("FAIL shift_a_sel: got %h expected 2", bus.A);
    else n_pass++;
    n_total++;
    if (bus.ALUResult !== 32'h4 || bus.zero !== 1'b0)
      $display("FAIL shift_sa: got %h/%b expected 4/0", bus.ALUResult, bus.zero);
    else n_pass++;
    model_reg = 32'h4;
    exp_q.push_back(model_reg);
    edge_and_check("shift_load");
    // upper A bits must be ignored: 0xFFFFFFE3 shifts by 3
    drive(1'b0, 1'b0, 3'b010, 32'hFFFF_FFE3, 32'h1, 5'd0, 32'h0, 1'b0);
    #1;
    n_total++;
    if (bus.ALUResult !== 32'h8) $display("FAIL shift_upper_ignored: got %h expected 8", bus.ALUResult);
    else n_pass++;
    exp_q.push_back(model_reg);
    edge_and_check("shift_hold");
  endtask

  task automatic test_zero_and_wrap();
    drive(1'b0, 1'b0, 3'b001, 32'h1234, 32'h1234, 5'd0, 32'h0, 1'b0);
    #1;
    n_total++;
    if (bus.ALUResult !== 32'h0 || bus.zero !== 1'b1)
      $display("FAIL sub_zero: got %h/%b expected 0/1", bus.ALUResult, bus.zero);
    else n_pass++;
    drive(1'b0, 1'b0, 3'b000, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0, 1'b0);
    #1;
    n_total++;
    if (bus.ALUResult !== 32'h0 || bus.zero !== 1'b1)
      $display("FAIL add_wrap: got %h/%b expected 0/1", bus.ALUResult, bus.zero);
    else n_pass++;
`ifdef ALU_OVERFLOW_EN
    n_total++;
    if (bus.overflow !== 1'b0) $display("FAIL add_wrap_ovf: got %b expected 0", bus.overflow);
    else n_pass++;
    drive(1'b0, 1'b0, 3'b000, 32'h7FFF_FFFF, 32'h1, 5'd0, 32'h0, 1'b0);
    #1;
    n_total++;
    if (bus.overflow !== 1'b1 || bus.ALUResult !== 32'h8000_0000)
      $display("FAIL add_ovf: got %b/%h expected 1/80000000", bus.overflow, bus.ALUResult);
    else n_pass++;
    drive(1'b0, 1'b0, 3'b001, 32'h8000_0000, 32'h1, 5'd0, 32'h0, 1'b0);
    #1;
    n_total++;
    if (bus.overflow !== 1'b1) $display("FAIL sub_ovf: got %b expected 1", bus.overflow);
    else n_pass++;
`endif
  endtask

  task automatic test_compare_and_imm();
    drive(1'b0, 1'b0, 3'b101, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0, 1'b0);
    #1;
    n_total++;
    if (bus.ALUResult !== 32'h0 || bus.zero !== 1'b1)
      $display("FAIL sltu: got %h/%b expected 0/1", bus.ALUResult, bus.zero);
    else n_pass++;
    drive(1'b0, 1'b0, 3'b110, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0, 1'b0);
    #1;
    n_total++;
    if (bus.ALUResult !== 32'h1 || bus.zero !== 1'b0)
      $display("FAIL slt: got %h/%b expected 1/0", bus.ALUResult, bus.zero);
    else n_pass++;
    drive(1'b0, 1'b1, 3'b100, 32'h1234_5678, 32'hAAAA_5555, 5'd0, 32'hFFFF_0000, 1'b1);
    #1;
    n_total++;
    if (bus.B !== 32'hFFFF_0000 || bus.ALUResult !== 32'h1234_0000)
      $display("FAIL and_imm: got B=%h R=%h expected ffff0000/12340000", bus.B, bus.ALUResult);
    else n_pass++;
    model_reg = 32'h1234_0000;
    exp_q.push_back(model_reg);
    edge_and_check("and_imm_load");
  endtask

  task automatic test_hold_and_async_reset();
    drive(1'b0, 1'b0, 3'b011, 32'hA000_0000, 32'h0000_000B, 5'd0, 32'h0, 1'b1);
    model_reg = 32'hA000_000B;
    exp_q.push_back(model_reg);
    edge_and_check("or_load");
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 3'b111, 32'h1111_1111 * (i + 1), 32'h0F0F_0F0F, 5'd0, 32'h0, 1'b0);
      exp_q.push_back(model_reg);
      edge_and_check("hold");
    end
    @(posedge CLK);
    #2;
    RST = 1'b0;
    #1;
    n_total++;
    if (bus.ALUOutReg !== 32'h0) $display("FAIL async_reset: got %h expected 0", bus.ALUOutReg);
    else n_pass++;
    model_reg = 32'h0;
    @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] r1, r2, ext, a_m, b_m, res;
    logic [4:0]   sav;
    logic [2:0]   op;
    logic         sa_sel, sb_sel, wre;
    for (int i = 0; i < 40; i++) begin
      r1 = $urandom; r2 = $urandom; ext = $urandom;
      sav = 5'($urandom_range(31, 0)); op = 3'($urandom_range(7, 0));
      sa_sel = 1'($urandom_range(1, 0)); sb_sel = 1'($urandom_range(1, 0));
      wre = 1'($urandom_range(1, 0));
      if (i % 5 == 0) r2 = r1;
      drive(sa_sel, sb_sel, op, r1, r2, sav, ext, wre);
      a_m = sa_sel ? {27'd0, sav} : r1;
      b_m = sb_sel ? ext : r2;
      res = ref_alu(op, a_m, b_m);
      #1;
      got = bus.ALUResult;
      n_total++;
      if (got !== res || bus.zero !== (res == 32'd0))
        $display("FAIL rand_comb op=%0d: got %h/%b expected %h/%b", op, got, bus.zero, res, (res == 32'd0));
      else n_pass++;
      if (wre) model_reg = res;
      exp_q.push_back(model_reg);
      edge_and_check("rand_reg");
    end
  endtask

  initial begin
    bus.ALUSrcA = 1'b0; bus.ALUSrcB = 1'b0; bus.ALUOp = 3'b000;
    bus.ReadData1 = 32'h0; bus.ReadData2 = 32'h0; bus.sa = 5'd0;
    bus.ExtendOut = 32'h0; bus.ALUOutWre = 1'b0;
    test_reset();
    test_shift();
    test_zero_and_wrap();
    test_compare_and_imm();
    test_hold_and_async_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
